gate_check_sequencer: RTL and testbench

//   Self-checking truth-table sequencer for small combinational gate pairs.
//   It drives every input vector in order to two implementations of the same

---
 rtl/gate_check_sequencer.sv | 159 +++++++++++++++
 tb/tb_gate_check_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_check_sequencer
// Brief    : Truth-table sweep that checks two implementations of one gate
//            against each other and against a golden table.
// Revision : 1.0 - initial release
// ============================================================================
module gate_check_sequencer #(
    parameter int unsigned              N_IN = 2,
    parameter int unsigned              HOLD = 1,
    parameter logic [(1<<N_IN)-1:0]     TT   = 4'b0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_o,
    input  logic            s_a,
    input  logic            s_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_vld
);

    localparam int unsigned     c_hcw       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_hcw-1:0] c_hold_last = c_hcw'(HOLD - 1);
    localparam logic [N_IN-1:0]  c_vec_last  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [N_IN-1:0]   r_vec,   w_vec;
    logic [c_hcw-1:0]  r_hold,  w_hold;
    logic              r_busy,  w_busy;
    logic              r_done,  w_done;
    logic              r_pass,  w_pass;
    logic [N_IN:0]     r_err,   w_err;
    logic [N_IN-1:0]   r_ff,    w_ff;
    logic              r_fvld,  w_fvld;
    logic              w_row_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ff    <= '0;
            r_fvld  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_vec   <= w_vec;
            r_hold  <= w_hold;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_ff    <= w_ff;
            r_fvld  <= w_fvld;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_vec      = r_vec;
        w_hold     = r_hold;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_pass     = r_pass;
        w_err      = r_err;
        w_ff       = r_ff;
        w_fvld     = r_fvld;
        w_row_fail = (s_a != s_b) || (s_a != TT[r_vec]) || (s_b != TT[r_vec]);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_DRIVE;
                    w_vec   = '0;
                    w_hold  = '0;
                    w_busy  = 1'b1;
                    w_pass  = 1'b0;
                    w_err   = '0;
                    w_ff    = '0;
                    w_fvld  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_vec   = '0;
                    w_hold  = '0;
                    w_busy  = 1'b0;
                    w_pass  = 1'b0;
                end else begin
                    w_hold = r_hold + c_hcw'(1);
                    if (r_hold == c_hold_last) begin
                        w_state = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // abort wins over the comparison: the row in flight is dropped
                if (abort) begin
                    w_state = S_IDLE;
                    w_vec   = '0;
                    w_hold  = '0;
                    w_busy  = 1'b0;
                    w_pass  = 1'b0;
                end else begin
                    if (w_row_fail) begin
                        w_err = r_err + (N_IN+1)'(1);
                        if (!r_fvld) begin
                            w_ff   = r_vec;
                            w_fvld = 1'b1;
                        end
                    end
                    if (r_vec == c_vec_last) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err == '0);
                    end else begin
                        w_state = S_DRIVE;
                        w_vec   = r_vec + N_IN'(1);
                        w_hold  = '0;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign vec_o      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err;
    assign first_fail = r_ff;
    assign fail_vld   = r_fvld;

endmodule
`default_nettype wire

// File: tb/tb_gate_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_check_sequencer
// Brief    : Drives modelled gate pairs into gate_check_sequencer and checks
//            sweep timing and result fields against a NOR reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_check_sequencer;

    localparam int         N_IN  = 2;
    localparam int         HOLD  = 1;
    localparam logic [3:0] TT    = 4'b0001;
    localparam int         ROWS  = 1 << N_IN;
    localparam int         SWEEP = ROWS * (HOLD + 1);

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [N_IN-1:0] vec_o;
    logic            s_a, s_b;
    logic            busy, done, pass, fail_vld;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_fail;

    // behaviour of the two gate implementations, one bit per row
    logic [3:0] a_tab = 4'b0001;
    logic [3:0] b_tab = 4'b0001;
    assign s_a = a_tab[vec_o];
    assign s_b = b_tab[vec_o];

    int n_checks = 0;
    int n_pass   = 0;

    gate_check_sequencer #(.N_IN(N_IN), .HOLD(HOLD), .TT(TT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .vec_o      (vec_o),
        .s_a        (s_a),
        .s_b        (s_b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail),
        .fail_vld   (fail_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // golden NOR evaluated on rows 0..rows-1 (row bit1 = a, bit0 = b)
    function automatic void model(input logic [3:0] at, input logic [3:0] bt,
                                  input int rows, output int errs, output int ff);
        logic g;
        errs = 0;
        ff   = -1;
        for (int m = 0; m < rows; m++) begin
            g = !(m[1] || m[0]);
            if (at[m] !== g || bt[m] !== g) begin
                errs++;
                if (ff < 0) ff = m;
            end
        end
    endfunction

    task automatic run_sweep(input logic [3:0] at, input logic [3:0] bt,
                             input bit poke, input string tag);
        int e, ff;
        a_tab = at;
        b_tab = bt;
        model(at, bt, ROWS, e, ff);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= SWEEP; j++) begin
            if (j < SWEEP) begin
                n_checks++;
                if (vec_o !== N_IN'(j / (HOLD + 1)))
                    $display("FAIL %s vec_o cyc %0d: got %0d want %0d", tag, j, vec_o, j / (HOLD + 1));
                else n_pass++;
                n_checks++;
                if (busy !== 1'b1) $display("FAIL %s busy cyc %0d: got %b want 1", tag, j, busy);
                else n_pass++;
            end
            n_checks++;
            if (done !== (j == SWEEP))
                $display("FAIL %s done cyc %0d: got %b want %b", tag, j, done, (j == SWEEP));
            else n_pass++;
            if (poke) start = (j == SWEEP) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s idle: got done=%b busy=%b want 0 0", tag, done, busy);
        else n_pass++;
        n_checks++;
        if (err_cnt !== (N_IN+1)'(e)) $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, e);
        else n_pass++;
        n_checks++;
        if (fail_vld !== (e > 0)) $display("FAIL %s fail_vld: got %b want %b", tag, fail_vld, (e > 0));
        else n_pass++;
        n_checks++;
        if (first_fail !== N_IN'((e > 0) ? ff : 0))
            $display("FAIL %s first_fail: got %0d want %0d", tag, first_fail, (e > 0) ? ff : 0);
        else n_pass++;
        n_checks++;
        if (pass !== (e == 0)) $display("FAIL %s pass: got %b want %b", tag, pass, (e == 0));
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL %s no_restart: got busy=%b done=%b want 0 0", tag, busy, done);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec_o, busy, done, pass, err_cnt, first_fail, fail_vld} !== '0)
            $display("FAIL reset outs: got vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b want all 0",
                     vec_o, busy, done, pass, err_cnt, first_fail, fail_vld);
        else n_pass++;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nor_ok();      run_sweep(4'b0001, 4'b0001, 1'b0, "nor_ok");   endtask
    task automatic test_stuck_b0();    run_sweep(4'b0001, 4'b0000, 1'b0, "b_sa0");    endtask
    task automatic test_stuck_a1();    run_sweep(4'b1111, 4'b0001, 1'b0, "a_sa1");    endtask
    task automatic test_start_ignored(); run_sweep(4'b0001, 4'b0001, 1'b1, "start_ign"); endtask

    task automatic test_abort();
        int k, e, ff, seen;
        logic [3:0] at, bt;
        at = 4'($urandom);
        bt = 4'($urandom);
        a_tab = at;
        b_tab = bt;
        model(at, bt, 2, e, ff);
        k = 4 + int'($urandom_range(0, 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < k; j++) tick();
        n_checks++;
        if (vec_o !== 2'd2) $display("FAIL abort pre vec_o: got %0d want 2", vec_o);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || vec_o !== '0 || done !== 1'b0 || pass !== 1'b0)
            $display("FAIL abort state: got busy=%b vec=%0d done=%b pass=%b want 0 0 0 0",
                     busy, vec_o, done, pass);
        else n_pass++;
        n_checks++;
        if (err_cnt !== (N_IN+1)'(e)) $display("FAIL abort err_cnt: got %0d want %0d", err_cnt, e);
        else n_pass++;
        n_checks++;
        if (fail_vld !== (e > 0) || first_fail !== N_IN'((e > 0) ? ff : 0))
            $display("FAIL abort fail_fields: got fv=%b ff=%0d want %b %0d",
                     fail_vld, first_fail, (e > 0), (e > 0) ? ff : 0);
        else n_pass++;
        seen = 0;
        for (int j = 0; j < SWEEP + 2; j++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort quiet: got %0d active cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        a_tab = 4'b0001;
        b_tab = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (err_cnt !== 3'd1 || busy !== 1'b1)
            $display("FAIL rst_mid pre: got err=%0d busy=%b want 1 1", err_cnt, busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec_o, busy, done, pass, err_cnt, first_fail, fail_vld} !== '0)
            $display("FAIL rst_mid outs: got vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b want all 0",
                     vec_o, busy, done, pass, err_cnt, first_fail, fail_vld);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_sweep(4'b0001, 4'b0001, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        logic [3:0] at, bt;
        for (int i = 0; i < 8; i++) begin
            at = TT ^ (4'($urandom) & 4'($urandom));
            bt = TT ^ (4'($urandom) & 4'($urandom));
            run_sweep(at, bt, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_nor_ok();
        test_stuck_b0();
        test_stuck_a1();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
